// File: rtl/sha256_msg_scheduler_pkg.sv
// Shared SHA-256 definitions: scheduler state encoding, round constants and the
// small sigma functions used by message expansion.
package sha256_msg_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } sched_state_t;

  localparam int NUM_ROUNDS = 64;

  localparam logic [31:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_msg_scheduler_k_rom.sv
// Combinational lookup of the SHA-256 round constant for a round index.
module sha256_k_rom
  import sha256_msg_scheduler_pkg::*;
(
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha256_msg_scheduler.sv
// Expands one 512-bit block into W[0..63], one word per accepted round.
//   state     | meaning
//   ST_IDLE   | waiting for a block, BLOCK_READY high
//   ST_RUN    | presenting W[I]/K[I]/I, advancing on ROUND_READY
//   ST_FINISH | one-cycle DONE pulse, then back to ST_IDLE
module sha256_msg_scheduler
  import sha256_msg_scheduler_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic [511:0] BLOCK_IN,
  input  logic         BLOCK_VALID,
  output logic         BLOCK_READY,
  output logic [31:0]  W_OUT,
  output logic [31:0]  K_OUT,
  output logic [5:0]   I_OUT,
  output logic         ROUND_VALID,
  input  logic         ROUND_READY,
  output logic         DONE
);

  sched_state_t state;
  logic [5:0]   round_idx;
  logic [31:0]  win [16];
  logic [31:0]  k_rom_val;
  logic [31:0]  expand_word;

  sha256_k_rom u_k_rom (
    .idx (round_idx),
    .k   (k_rom_val)
  );

  // Next schedule word; only ever written into win[15].
  assign expand_word = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      round_idx <= '0;
      for (int j = 0; j < 16; j++) win[j] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (BLOCK_VALID) begin
            for (int j = 0; j < 16; j++) win[j] <= BLOCK_IN[511 - 32*j -: 32];
            round_idx <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (ROUND_READY) begin
            for (int j = 0; j < 15; j++) win[j] <= win[j+1];
            win[15]   <= expand_word;
            round_idx <= round_idx + 6'd1;
            if (round_idx == 6'(NUM_ROUNDS - 1)) state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs are held low for the whole time RESET is asserted.
  assign BLOCK_READY = (state == ST_IDLE)   && !RESET;
  assign ROUND_VALID = (state == ST_RUN)    && !RESET;
  assign DONE        = (state == ST_FINISH) && !RESET;

  assign W_OUT = win[0];
  assign I_OUT = round_idx;
  assign K_OUT = (state == ST_RUN) ? k_rom_val : '0;

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Self-checking bench: fixed "abc" vectors plus randomized blocks against a schedule model.
module tb_sha256_msg_scheduler;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [511:0] BLOCK_IN;
  logic         BLOCK_VALID;
  logic         BLOCK_READY;
  logic [31:0]  W_OUT;
  logic [31:0]  K_OUT;
  logic [5:0]   I_OUT;
  logic         ROUND_VALID;
  logic         ROUND_READY;
  logic         DONE;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];
  logic [31:0] got_k [64];

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    int          idx;
    logic [31:0] w;
    logic [31:0] k;
    bit          chk_w;
  } vec_t;

  vec_t vecs [7];

  always #5 CLK = ~CLK;

  sha256_msg_scheduler dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .BLOCK_IN    (BLOCK_IN),
    .BLOCK_VALID (BLOCK_VALID),
    .BLOCK_READY (BLOCK_READY),
    .W_OUT       (W_OUT),
    .K_OUT       (K_OUT),
    .I_OUT       (I_OUT),
    .ROUND_VALID (ROUND_VALID),
    .ROUND_READY (ROUND_READY),
    .DONE        (DONE)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = blk[511 - 32*t -: 32];
      else        exp_w[t] = ssig1(exp_w[t-2]) + exp_w[t-7] + ssig0(exp_w[t-15]) + exp_w[t-16];
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic run_block(input logic [511:0] blk, input bit rnd, input int stall_idx,
                           input int abort_idx, input bit hold, input logic [511:0] next_blk);
    int n, cyc, stall_left, dones;
    build_model(blk);
    BLOCK_IN    = blk;
    BLOCK_VALID = 1'b1;
    ROUND_READY = 1'b0;
    cyc = 0;
    while (!BLOCK_READY && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    check("accept_ready", 32'(BLOCK_READY), 32'd1);
    if (!BLOCK_READY) return;
    @(negedge CLK);
    if (hold) BLOCK_IN = next_blk;
    else begin
      BLOCK_VALID = 1'b0;
      BLOCK_IN    = '0;
    end
    n = 0; cyc = 0; stall_left = 3;
    while (n < 64 && cyc < 2000) begin
      check("round_valid", 32'(ROUND_VALID), 32'd1);
      check("block_ready_busy", 32'(BLOCK_READY), 32'd0);
      check("done_early", 32'(DONE), 32'd0);
      check($sformatf("i_out[%0d]", n), 32'(I_OUT), 32'(n));
      check($sformatf("w_out[%0d]", n), W_OUT, exp_w[n]);
      check($sformatf("k_out[%0d]", n), K_OUT, K_REF[n]);
      got_w[n] = W_OUT;
      got_k[n] = K_OUT;
      if (n == abort_idx) begin
        RESET = 1'b1;
        ROUND_READY = 1'b1;
        @(negedge CLK);
        check("rst_round_valid", 32'(ROUND_VALID), 32'd0);
        check("rst_block_ready", 32'(BLOCK_READY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("post_rst_block_ready", 32'(BLOCK_READY), 32'd1);
        check("post_rst_round_valid", 32'(ROUND_VALID), 32'd0);
        check("post_rst_i_out", 32'(I_OUT), 32'd0);
        check("post_rst_w_out", W_OUT, 32'd0);
        check("post_rst_k_out", K_OUT, 32'd0);
        dones = 0;
        for (int c = 0; c < 70; c++) begin
          if (DONE) dones++;
          @(negedge CLK);
        end
        check("post_rst_no_done", 32'(dones), 32'd0);
        ROUND_READY = 1'b0;
        return;
      end
      if (n == stall_idx && stall_left > 0) begin
        ROUND_READY = 1'b0;
        stall_left--;
      end else begin
        ROUND_READY = rnd ? 1'($urandom_range(1)) : 1'b1;
      end
      if (ROUND_READY) n++;
      @(negedge CLK);
      cyc++;
    end
    if (!rnd) check("run_cycles", 32'(cyc), (stall_idx >= 0) ? 32'd67 : 32'd64);
    ROUND_READY = 1'b1;
    check("finish_done", 32'(DONE), 32'd1);
    check("finish_round_valid", 32'(ROUND_VALID), 32'd0);
    check("finish_block_ready", 32'(BLOCK_READY), 32'd0);
    @(negedge CLK);
    check("idle_done", 32'(DONE), 32'd0);
    check("idle_block_ready", 32'(BLOCK_READY), 32'd1);
    check("idle_round_valid", 32'(ROUND_VALID), 32'd0);
    ROUND_READY = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, b1, b2;
    abc = {32'h61626380, 448'b0, 32'h00000018};

    vecs[0] = '{0,  32'h61626380, 32'h428a2f98, 1'b1};
    vecs[1] = '{1,  32'h00000000, 32'h71374491, 1'b1};
    vecs[2] = '{14, 32'h00000000, 32'h9bdc06a7, 1'b1};
    vecs[3] = '{15, 32'h00000018, 32'hc19bf174, 1'b1};
    vecs[4] = '{16, 32'h61626380, 32'he49b69c1, 1'b1};
    vecs[5] = '{17, 32'h000f0000, 32'hefbe4786, 1'b1};
    vecs[6] = '{63, 32'h00000000, 32'hc67178f2, 1'b0};

    RESET = 1'b1; BLOCK_VALID = 1'b0; BLOCK_IN = '0; ROUND_READY = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_block_ready", 32'(BLOCK_READY), 32'd0);
    check("reset_round_valid", 32'(ROUND_VALID), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    check("reset_i_out", 32'(I_OUT), 32'd0);
    check("reset_w_out", W_OUT, 32'd0);
    check("reset_k_out", K_OUT, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    check("release_block_ready", 32'(BLOCK_READY), 32'd1);

    run_block(abc, 1'b0, -1, -1, 1'b0, '0);
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].chk_w) check($sformatf("abc_w[%0d]", vecs[v].idx), got_w[vecs[v].idx], vecs[v].w);
      check($sformatf("abc_k[%0d]", vecs[v].idx), got_k[vecs[v].idx], vecs[v].k);
    end

    run_block(rand_block(), 1'b0, -1, -1, 1'b0, '0);
    run_block(rand_block(), 1'b0, 5, -1, 1'b0, '0);

    b1 = rand_block();
    b2 = rand_block();
    run_block(b1, 1'b0, -1, -1, 1'b1, b2);
    run_block(b2, 1'b0, -1, -1, 1'b0, '0);

    run_block(rand_block(), 1'b0, -1, 20, 1'b0, '0);
    run_block(abc, 1'b0, -1, -1, 1'b0, '0);

    for (int b = 0; b < 100; b++) run_block(rand_block(), 1'b1, -1, -1, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
